// File: rtl/db_req_arb_if.sv
// Request, DB issue/result and response signals of the two-port DB lookup arbiter.
// master = requester/DB side, slave = arbiter side.
interface db_req_arb_if #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [KEY_SIZE-1:0]  req0_key;
  logic [FLAG_SIZE-1:0] req0_flag;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [KEY_SIZE-1:0]  req1_key;
  logic [FLAG_SIZE-1:0] req1_flag;
  logic                 db_valid;
  logic [KEY_SIZE-1:0]  db_key;
  logic [FLAG_SIZE-1:0] db_flag;
  logic                 db_out_valid;
  logic [FLAG_SIZE-1:0] db_out_flag;
  logic                 rsp0_valid;
  logic                 rsp1_valid;
  logic [FLAG_SIZE-1:0] rsp_flag;

  modport master (
    output req0_valid, req0_key, req0_flag,
    output req1_valid, req1_key, req1_flag,
    input  req0_ready, req1_ready,
    input  db_valid, db_key, db_flag,
    output db_out_valid, db_out_flag,
    input  rsp0_valid, rsp1_valid, rsp_flag
  );

  modport slave (
    input  req0_valid, req0_key, req0_flag,
    input  req1_valid, req1_key, req1_flag,
    output req0_ready, req1_ready,
    output db_valid, db_key, db_flag,
    input  db_out_valid, db_out_flag,
    output rsp0_valid, rsp1_valid, rsp_flag
  );
endinterface

// File: rtl/db_req_arb.sv
// Two-port round-robin arbiter onto the DB lookup path with credit limit and in-order tag return.
// Optional per-port grant counters enabled by macro ARB_STATS_EN.
module db_req_arb #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int MAX_OUT   = 8,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  db_req_arb_if.slave              bus,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_spurious,
  output logic [CNT_W-1:0]         grant_cnt0,
  output logic [CNT_W-1:0]         grant_cnt1
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int OUT_W = PTR_W + 1;

  logic             rr_last;   // port granted most recently
  logic             credit;
  logic             empty;
  logic             grant0;
  logic             grant1;
  logic             push;
  logic             pop;
  logic             tag_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign credit = outstanding < OUT_W'(MAX_OUT);
  assign empty  = (outstanding == '0);

  // Ready is gated by rst so all outputs read 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && credit) begin
      if (bus.req0_valid && (!bus.req1_valid || rr_last))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign push = grant0 | grant1;
  assign pop  = bus.db_out_valid & ~empty;

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= grant1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last      <= 1'b1;
      bus.db_valid <= 1'b0;
      bus.db_key   <= '0;
      bus.db_flag  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_flag <= '0;
      err_spurious <= 1'b0;
    end else begin
      bus.db_valid <= push;
      if (push) begin
        rr_last     <= grant1;
        bus.db_key  <= grant1 ? bus.req1_key  : bus.req0_key;
        bus.db_flag <= grant1 ? bus.req1_flag : bus.req0_flag;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end

      bus.rsp0_valid <= pop & ~tag_mem[rd_ptr];
      bus.rsp1_valid <= pop &  tag_mem[rd_ptr];
      if (pop) begin
        bus.rsp_flag <= bus.db_out_flag;
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (bus.db_out_valid && empty)
        err_spurious <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule
